// File: rtl/node_pkg.sv
// node_pkg: shared node-name and dense-index types used by the decoder, indexer and path-count stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package node_pkg;

  // A node name is three characters, each packed as a 5-bit code.
  localparam int NODE_CHARS      = 3;
  localparam int NODE_BIN_BITS   = 5;
  localparam int NODE_WIDTH      = NODE_CHARS * NODE_BIN_BITS;

  // Widest dense index any stage stores; narrower indexers zero-extend into it.
  localparam int MAX_INDEX_WIDTH = 10;

  typedef logic [NODE_WIDTH-1:0]      node_t;
  typedef logic [MAX_INDEX_WIDTH-1:0] idx_t;

  // One lookup-table entry: has this name been allocated, and to which index.
  typedef struct packed {
    logic valid;
    idx_t idx;
  } lut_entry_t;

  // Indexer life cycle: clear the table, index edges, flush the pipeline, then park.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ix_state_e;

  // Packs three 5-bit character codes into a node name, first character in the MSBs.
  function automatic node_t make_node(input logic [NODE_BIN_BITS-1:0] c0,
                                      input logic [NODE_BIN_BITS-1:0] c1,
                                      input logic [NODE_BIN_BITS-1:0] c2);
    return {c0, c1, c2};
  endfunction

endpackage

// File: rtl/node_indexer_lut_ram.sv
// node_lut_ram: 2**NODE_WIDTH x lut_entry_t table, two ports each with its own read and write address.
// Latency: 1 cycle read; read-first, so a read and a write to one address on the same edge returns old data.
// Backpressure: none; every port accepts one read and one write per cycle.
module node_lut_ram
  import node_pkg::*;
(
  input  logic       clk,
  input  node_t      rd_addr_a,
  output lut_entry_t rd_data_a,
  input  logic       wr_en_a,
  input  node_t      wr_addr_a,
  input  lut_entry_t wr_data_a,
  input  node_t      rd_addr_b,
  output lut_entry_t rd_data_b,
  input  logic       wr_en_b,
  input  node_t      wr_addr_b,
  input  lut_entry_t wr_data_b
);

  lut_entry_t mem [2**NODE_WIDTH];

  // Registered reads sample the array before this edge's writes land (read-first).
  always_ff @(posedge clk) begin
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
    if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
    if (wr_en_b) mem[wr_addr_b] <= wr_data_b;
  end

endmodule

// File: rtl/node_indexer.sv
// node_indexer: maps node names to dense first-seen indices and re-emits each edge as an index pair.
// Latency: edge_valid at cycle t -> idx_edge_valid at t+2; table clear of 2**(NODE_WIDTH-1) cycles after reset.
// Backpressure: none; edges may arrive every cycle in RUN, edges outside RUN are discarded and flagged.
module node_indexer
  import node_pkg::*;
#(
  parameter int INDEX_WIDTH = MAX_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   edge_valid,
  input  logic [NODE_WIDTH-1:0]  src_node,
  input  logic [NODE_WIDTH-1:0]  dst_node,
  input  logic                   decoding_done,
  output logic                   init_done,
  output logic                   idx_edge_valid,
  output logic [INDEX_WIDTH-1:0] src_idx,
  output logic [INDEX_WIDTH-1:0] dst_idx,
  output logic [INDEX_WIDTH:0]   node_count,
  output logic                   indexing_done,
  output logic                   overflow,
  output logic                   dropped
);

  localparam int                   CLR_W     = NODE_WIDTH - 1;
  localparam logic [INDEX_WIDTH:0] CNT_ONE   = (INDEX_WIDTH + 1)'(1);
  localparam logic [INDEX_WIDTH:0] MAX_NODES = CNT_ONE << INDEX_WIDTH;

  ix_state_e state, state_nx;
  logic [CLR_W-1:0] clr_cnt;
  logic clr_last;
  logic in_run;
  logic accept;

  // S1: names whose table entries are being read this cycle.
  logic  s1_vld;
  node_t s1_src;
  node_t s1_dst;

  // Table ports.
  lut_entry_t rd_a, rd_b;
  logic       wr_en_a, wr_en_b;
  node_t      wr_addr_a, wr_addr_b;
  lut_entry_t wr_data_a, wr_data_b;

  // Entries written by the previous S2 cycle; the RAM read issued on that same edge missed them.
  logic       byp_a_vld, byp_b_vld;
  node_t      byp_a_name, byp_b_name;
  lut_entry_t byp_a_ent, byp_b_ent;

  // S2 resolution results.
  lut_entry_t             src_ent, dst_ent;
  logic [INDEX_WIDTH-1:0] src_res, dst_res;
  logic                   src_alloc, dst_alloc;
  logic                   ovf_now;
  logic [INDEX_WIDTH:0]   cnt_mid, cnt_nx;

  assign clr_last = &clr_cnt;
  assign in_run   = (state == ST_RUN);
  assign accept   = edge_valid && in_run;

  // Next-state logic: clear once, run until the decoder finishes, drain, then park until reset.
  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (clr_last)       state_nx = ST_RUN;
      ST_RUN:   if (decoding_done)  state_nx = ST_DRAIN;
      ST_DRAIN: if (!s1_vld)        state_nx = ST_DONE;
      ST_DONE:                      state_nx = ST_DONE;
      default:                      state_nx = ST_CLEAR;
    endcase
  end

  // State register and clear address counter; reset always restarts a full clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  node_lut_ram u_lut (
    .clk       (clk),
    .rd_addr_a (src_node),
    .rd_data_a (rd_a),
    .wr_en_a   (wr_en_a),
    .wr_addr_a (wr_addr_a),
    .wr_data_a (wr_data_a),
    .rd_addr_b (dst_node),
    .rd_data_b (rd_b),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b)
  );

  // Write ports: clear two adjacent addresses per cycle in CLEAR, otherwise store S2 allocations.
  always_comb begin
    wr_en_a   = src_alloc;
    wr_addr_a = s1_src;
    wr_data_a = '{valid: 1'b1, idx: idx_t'(src_res)};
    wr_en_b   = dst_alloc;
    wr_addr_b = s1_dst;
    wr_data_b = '{valid: 1'b1, idx: idx_t'(dst_res)};
    if (state == ST_CLEAR) begin
      wr_en_a   = 1'b1;
      wr_addr_a = {clr_cnt, 1'b0};
      wr_data_a = '0;
      wr_en_b   = 1'b1;
      wr_addr_b = {clr_cnt, 1'b1};
      wr_data_b = '0;
    end
  end

  // S2: pick freshest entry per name, then hit -> stored index, miss -> allocate (src first).
  always_comb begin
    src_ent   = rd_a;
    dst_ent   = rd_b;
    src_res   = '0;
    dst_res   = '0;
    src_alloc = 1'b0;
    dst_alloc = 1'b0;
    ovf_now   = 1'b0;
    cnt_mid   = node_count;
    cnt_nx    = node_count;

    if (byp_b_vld && (byp_b_name == s1_src)) src_ent = byp_b_ent;
    if (byp_a_vld && (byp_a_name == s1_src)) src_ent = byp_a_ent;
    if (byp_a_vld && (byp_a_name == s1_dst)) dst_ent = byp_a_ent;
    if (byp_b_vld && (byp_b_name == s1_dst)) dst_ent = byp_b_ent;

    if (s1_vld) begin
      if (src_ent.valid) begin
        src_res = src_ent.idx[INDEX_WIDTH-1:0];
      end else if (node_count < MAX_NODES) begin
        src_res   = node_count[INDEX_WIDTH-1:0];
        src_alloc = 1'b1;
        cnt_mid   = node_count + CNT_ONE;
      end else begin
        src_res = '1;
        ovf_now = 1'b1;
      end
      cnt_nx = cnt_mid;

      // A self-loop shares the source's resolution so the name is never allocated twice.
      if (s1_src == s1_dst) begin
        dst_res = src_res;
      end else if (dst_ent.valid) begin
        dst_res = dst_ent.idx[INDEX_WIDTH-1:0];
      end else if (cnt_mid < MAX_NODES) begin
        dst_res   = cnt_mid[INDEX_WIDTH-1:0];
        dst_alloc = 1'b1;
        cnt_nx    = cnt_mid + CNT_ONE;
      end else begin
        dst_res = '1;
        ovf_now = 1'b1;
      end
    end
  end

  // S1 capture and bypass registers holding exactly the previous cycle's writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld     <= 1'b0;
      s1_src     <= '0;
      s1_dst     <= '0;
      byp_a_vld  <= 1'b0;
      byp_a_name <= '0;
      byp_a_ent  <= '0;
      byp_b_vld  <= 1'b0;
      byp_b_name <= '0;
      byp_b_ent  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_src <= src_node;
        s1_dst <= dst_node;
      end
      byp_a_vld  <= src_alloc;
      byp_a_name <= s1_src;
      byp_a_ent  <= wr_data_a;
      byp_b_vld  <= dst_alloc;
      byp_b_name <= s1_dst;
      byp_b_ent  <= wr_data_b;
    end
  end

  // Registered outputs: index pair, allocation count, status flags and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done      <= 1'b0;
      idx_edge_valid <= 1'b0;
      src_idx        <= '0;
      dst_idx        <= '0;
      node_count     <= '0;
      indexing_done  <= 1'b0;
      overflow       <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      idx_edge_valid <= s1_vld;
      if (s1_vld) begin
        src_idx <= src_res;
        dst_idx <= dst_res;
      end
      node_count    <= cnt_nx;
      indexing_done <= (state == ST_DRAIN) && (state_nx == ST_DONE);
      if ((state == ST_CLEAR) && clr_last) init_done <= 1'b1;
      if (ovf_now) overflow <= 1'b1;
      if (edge_valid && !in_run) dropped <= 1'b1;
    end
  end

endmodule
